// File: rtl/fifo_tx_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_tx_reader
// Description : Pops words from a FIFO and sends each one as an 8N1-style
//               serial frame (start, LSB-first payload, [parity], stop).
//               Optional even parity: define FIFO_TX_READER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_tx_reader #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_ready,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  pop_clock,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int c_CNT_W        = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
    localparam int c_BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef FIFO_TX_READER_PARITY_EN
        S_PARITY = 3'd6,
`endif
        S_STOP   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [c_CNT_W-1:0]    r_clk_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  w_bit_end;
`ifdef FIFO_TX_READER_PARITY_EN
    logic                  r_parity;
`endif

    assign w_bit_end = (r_clk_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                // fifo_empty only matters here; a refill mid-frame waits for IDLE
                if (enable && fifo_ready && !fifo_empty) begin
                    w_next_state = S_POP;
                end
            end
            S_POP:   w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_START;
            S_START: begin
                if (w_bit_end) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == c_BIT_LAST)) begin
`ifdef FIFO_TX_READER_PARITY_EN
                    w_next_state = S_PARITY;
`else
                    w_next_state = S_STOP;
`endif
                end
            end
`ifdef FIFO_TX_READER_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[0];
`ifdef FIFO_TX_READER_PARITY_EN
            S_PARITY: tx = r_parity;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign pop_clock = (r_state == S_POP);
    assign busy      = (r_state != S_IDLE);
    assign tx_done   = (r_state == S_STOP) && w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef FIFO_TX_READER_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shift   <= fifo_data;
                    r_bit_cnt <= '0;
                    r_clk_cnt <= '0;
`ifdef FIFO_TX_READER_PARITY_EN
                    r_parity  <= ^fifo_data;
`endif
                end
                S_DATA: begin
                    r_clk_cnt <= w_bit_end ? '0 : (r_clk_cnt + c_CNT_ONE);
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        // saturate so the counter never wraps on the last bit
                        if (r_bit_cnt != c_BIT_LAST) begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                        end
                    end
                end
                S_START,
`ifdef FIFO_TX_READER_PARITY_EN
                S_PARITY,
`endif
                S_STOP: begin
                    r_clk_cnt <= w_bit_end ? '0 : (r_clk_cnt + c_CNT_ONE);
                end
                default: begin
                    r_clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_tx_reader
// Description : Randomized scoreboard bench: FIFO model feeds the DUT, a
//               serial-line receiver model checks every frame cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_tx_reader;

    localparam int CPB = 10;
    localparam int DW  = 8;
`ifdef FIFO_TX_READER_PARITY_EN
    localparam int NB  = DW + 3;
`else
    localparam int NB  = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_ready;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          pop_clock;
    logic          tx;
    logic          busy;
    logic          tx_done;

    fifo_tx_reader #(
        .CLK_FREQ_HZ (1000000),
        .BAUD_RATE   (100000),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_ready (fifo_ready),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .pop_clock  (pop_clock),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int pop_count = 0;
    int done_cnt = 0;
    int frames_done = 0;
    int frames_aborted = 0;
    int frame_starts = 0;
    int last_end = -1000;
    int last_gap = 0;
    bit mon_en = 1'b0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, ncyc);
        end
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // FIFO model: a pop strobe seen in a cycle delivers the next word after that edge
    initial begin
        forever begin
            @(negedge clk);
            if (pop_clock === 1'b1) begin
                pop_count++;
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_pop: got pop with fifo size 0 want no pop (cycle %0d)", ncyc);
                end
                @(posedge clk);
                #1;
                if (fq.size() > 0) fifo_data = fq.pop_front();
                fifo_empty = (fq.size() == 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_done === 1'b1) done_cnt++;
        end
    end

    // Receiver model: expected frame built from the byte's bits, checked every cycle
    task automatic run_frame();
        logic [DW-1:0] eb;
        logic [NB-1:0] ev;
        logic [NB-1:0] rv;
        bit stable = 1'b1;
        bit ctl_ok = 1'b1;
        bit ab = 1'b0;
        frame_starts++;
        eb = '0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got start bit want idle line (cycle %0d)", ncyc);
        end else begin
            eb = exp_q.pop_front();
        end
        last_gap = ncyc - last_end - 1;
        ev = '0;
        rv = '0;
        for (int i = 0; i < DW; i++) ev[1+i] = eb[i];
`ifdef FIFO_TX_READER_PARITY_EN
        ev[DW+1] = ^eb;
`endif
        ev[NB-1] = 1'b1;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (rst) begin
                    ab = 1'b1;
                    break;
                end
                if (c == 0) rv[b] = tx;
                else if (tx !== rv[b]) stable = 1'b0;
                if (tx_done !== ((b == NB-1) && (c == CPB-1))) ctl_ok = 1'b0;
                if (busy !== 1'b1) ctl_ok = 1'b0;
            end
            if (ab) break;
        end
        if (ab) begin
            frames_aborted++;
        end else begin
            checks++;
            if (rv != ev || !stable) begin
                errors++;
                $display("FAIL frame_bits: got %h stable=%0d want %h (byte %h)", rv, stable, ev, eb);
            end
            checks++;
            if (!ctl_ok) begin
                errors++;
                $display("FAIL frame_ctl: got tx_done/busy misplaced want pulse on last stop cycle (byte %h)", eb);
            end
            frames_done++;
            last_end = ncyc;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst && tx == 1'b0) run_frame();
        end
    end

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, frames_done, target);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish (cycle %0d)", ncyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d0;
        int f0;
        int s0;
        int budget;
        logic [DW-1:0] rb;

        rst = 1'b1;
        enable = 1'b1;
        fifo_ready = 1'b1;
        fifo_empty = 1'b0;
        fifo_data = '0;

        // Reset with a (fake) non-empty FIFO: no pop may leak out
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_tx", int'(tx), 1);
            check("rst_busy", int'(busy), 0);
            check("rst_pop", int'(pop_clock), 0);
            check("rst_done", int'(tx_done), 0);
        end
        @(posedge clk);
        #1;
        fifo_empty = 1'b1;
        rst = 1'b0;
        mon_en = 1'b1;
        cycles(5);
        check("idle_busy", int'(busy), 0);
        check("idle_pops", pop_count, 0);

        // Single byte
        p0 = pop_count; d0 = done_cnt; f0 = frames_done;
        push_byte(8'hA5);
        wait_frames(f0 + 1, 200, "single_timeout");
        cycles(2);
        check("single_pops", pop_count, p0 + 1);
        check("single_done", done_cnt, d0 + 1);
        check("single_busy", int'(busy), 0);

        // Back-to-back
        enable = 1'b0;
        p0 = pop_count; f0 = frames_done;
        push_byte(8'h55);
        push_byte(8'hAA);
        enable = 1'b1;
        wait_frames(f0 + 2, 400, "b2b_timeout");
        check("b2b_gap", last_gap, 3);
        cycles(30);
        check("b2b_pops", pop_count, p0 + 2);
        check("b2b_busy", int'(busy), 0);

        // Enable dropped mid-frame
        enable = 1'b0;
        p0 = pop_count; f0 = frames_done;
        push_byte(8'h3C);
        push_byte(8'hC3);
        enable = 1'b1;
        cycles(30);
        enable = 1'b0;
        wait_frames(f0 + 1, 200, "gate_timeout");
        cycles(40);
        check("gate_pops_held", pop_count, p0 + 1);
        check("gate_busy", int'(busy), 0);
        enable = 1'b1;
        wait_frames(f0 + 2, 200, "gate_resume_timeout");
        check("gate_pops_resume", pop_count, p0 + 2);

        // Abort by reset on cycle 45 of a frame
        enable = 1'b0;
        f0 = frames_done; s0 = frame_starts;
        push_byte(8'h96);
        push_byte(8'h69);
        enable = 1'b1;
        budget = 0;
        while (frame_starts == s0 && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("abort_start_seen", int'(frame_starts > s0), 1);
        repeat (44) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        p0 = pop_count; d0 = done_cnt;
        @(posedge clk);
        @(negedge clk);
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(tx_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_no_pop", pop_count, p0);
        check("abort_aborted", frames_aborted, 1);
        wait_frames(f0 + 1, 200, "abort_restart_timeout");
        check("abort_restart_pops", pop_count, p0 + 1);
        check("abort_restart_done", done_cnt, d0 + 1);

        // Randomized traffic with enable/fifo_ready toggling
        f0 = frames_done;
        for (int i = 0; i < 24; i++) begin
            if (i == 0) rb = 8'h07;
            else if (i == 1) rb = 8'h03;
            else rb = DW'($urandom_range(0, 255));
            push_byte(rb);
            enable = ($urandom_range(0, 3) != 0);
            fifo_ready = ($urandom_range(0, 3) != 0);
            cycles($urandom_range(0, 150));
        end
        enable = 1'b1;
        fifo_ready = 1'b1;
        budget = 0;
        while ((exp_q.size() != 0 || busy) && budget < 4000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        cycles(3);
        check("rand_frames", frames_done, f0 + 24);
        check("rand_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_tx_reader.md
FIFO_TX_READER -- requirements
Module: fifo_tx_reader

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, bits per frame payload.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits starting new frames.
REQ-007 SHALL have port fifo_ready  input  1  FIFO usable (enabled and not being cleared).
REQ-008 SHALL have port fifo_empty  input  1  FIFO holds no data (driven from FIFO popped_last).
REQ-009 SHALL have port fifo_data  input  DATA_WIDTH  FIFO output word, valid one cycle after pop.
REQ-010 SHALL have port pop_clock  output  1  one-cycle pop strobe to FIFO.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-014 SHALL derive CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division); every bit period lasts exactly CLKS_PER_BIT cycles.
REQ-015 SHALL implement states IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
REQ-016 IDLE -> POP when enable && fifo_ready && !fifo_empty; otherwise remain in IDLE with tx=1.
REQ-017 POP: pop_clock=1 for exactly one cycle, then -> LOAD; pop_clock SHALL be 0 in every other state.
REQ-018 LOAD: capture fifo_data into shift register, clear bit counter, -> START.
REQ-019 START: tx=0 for CLKS_PER_BIT cycles, -> DATA.
REQ-020 DATA: shift DATA_WIDTH bits LSB first, one per bit period; after last bit -> PARITY if compiled in, else -> STOP.
REQ-021 STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 on final cycle; -> IDLE.
REQ-022 Back-to-back: with FIFO non-empty, tx SHALL stay high exactly 3 cycles (IDLE, POP, LOAD) between stop-bit end and next start bit.
REQ-023 Deassertion of enable or fifo_ready mid-frame SHALL NOT abort the frame; it only blocks the next IDLE -> POP transition.
REQ-024 fifo_empty SHALL be sampled only in IDLE; changes in other states are ignored.
REQ-025 Bit-period counter and bit counter SHALL be wide enough for CLKS_PER_BIT-1 and DATA_WIDTH-1 without wrap-around.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, tx=1, pop_clock=0, busy=0, tx_done=0, counters and shift register=0.
REQ-027 rst asserted mid-frame SHALL abort the frame immediately (tx=1 next cycle) and SHALL NOT issue a pop.
REQ-028 rst SHALL take priority over all other inputs.

Configuration
REQ-029 Macro FIFO_TX_READER_PARITY_EN SHALL, when defined, add a PARITY state sending even parity (XOR of payload bits) for one bit period between DATA and STOP; frame = DATA_WIDTH+3 bits.
REQ-030 Without FIFO_TX_READER_PARITY_EN, PARITY state and logic SHALL be absent; frame = DATA_WIDTH+2 bits.

Verification (CLK_FREQ_HZ=1000000, BAUD_RATE=100000 -> CLKS_PER_BIT=10)
REQ-031 Reset: hold rst 3 cycles with fifo_empty=0 -> tx=1, busy=0, pop_clock never pulses during reset.
REQ-032 Single byte: FIFO holds 0xA5, enable=1 -> one pop_clock pulse, tx = 0,1,0,1,0,0,1,0,1,1 each 10 cycles (no parity), tx_done pulse once, busy low afterward.
REQ-033 Parity build: byte 0x07 -> parity bit 1 sent after bit 7; byte 0x03 -> parity bit 0; frame 110 cycles.
REQ-034 Back-to-back: FIFO holds 0x55,0xAA -> two pops, exactly 3 idle-high cycles between first stop end and second start; fifo_empty asserted after second pop -> no third pop.
REQ-035 Gating: enable dropped in DATA of frame 1 with 2 bytes queued -> frame 1 completes intact, no second pop until enable returns.
REQ-036 Abort: rst asserted on cycle 45 of a frame -> tx=1 next cycle, busy=0, no tx_done, restart pops next byte only after rst release.
